avalon_simple_master: RTL and testbench



---
 rtl/av_pkg.sv | 24 ++
 rtl/avalon_simple_master.sv | 116 +++++++++++
 tb/tb_avalon_simple_master.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/av_pkg.sv
// ----------------------------------------------------------------------------
// av_pkg : shared Avalon-MM master types (FSM states, response codes, widths)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package av_pkg;

  localparam int AV_DATA_WIDTH = 32;
  localparam int BE_WIDTH      = AV_DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    RSP_OK      = 1'b0,
    RSP_TIMEOUT = 1'b1
  } rsp_code_e;

endpackage : av_pkg

`default_nettype wire

// File: rtl/avalon_simple_master.sv
// ----------------------------------------------------------------------------
// avalon_simple_master : single-outstanding Avalon-MM initiator with timeout
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module avalon_simple_master
  import av_pkg::*;
#(
  parameter int ADDR_WIDTH     = 30,
  parameter int DATA_WIDTH     = AV_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_Cmd_Valid,
  output logic                    o_Cmd_Ready,
  input  logic                    i_Cmd_Write,
  input  logic [ADDR_WIDTH-1:0]   i_Cmd_Addr,
  input  logic [DATA_WIDTH/8-1:0] i_Cmd_ByteEn,
  input  logic [DATA_WIDTH-1:0]   i_Cmd_WriteData,
  output logic                    o_Rsp_Valid,
  output logic [DATA_WIDTH-1:0]   o_Rsp_ReadData,
  output logic                    o_Rsp_Error,
  output logic [ADDR_WIDTH-1:0]   o_AV_Addr,
  output logic [DATA_WIDTH/8-1:0] o_AV_ByteEn,
  output logic                    o_AV_Read,
  output logic                    o_AV_Write,
  output logic [DATA_WIDTH-1:0]   o_AV_WriteData,
  input  logic [DATA_WIDTH-1:0]   i_AV_ReadData,
  input  logic                    i_AV_WaitRequest
);

  localparam int BEW = DATA_WIDTH / 8;
  // Counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                  state_q;
  logic [CW-1:0]           wait_cnt_q;
  logic [ADDR_WIDTH-1:0]   av_addr_q;
  logic [BEW-1:0]          av_be_q;
  logic [DATA_WIDTH-1:0]   av_wdata_q;
  logic                    av_read_q;
  logic                    av_write_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  rsp_code_e               rsp_code_q;

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TO_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      av_addr_q   <= '0;
      av_be_q     <= '0;
      av_wdata_q  <= '0;
      av_read_q   <= 1'b0;
      av_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_code_q  <= RSP_OK;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Cmd_Valid) begin
            av_addr_q  <= i_Cmd_Addr;
            av_be_q    <= i_Cmd_ByteEn;
            av_wdata_q <= i_Cmd_WriteData;
            av_write_q <= i_Cmd_Write;
            av_read_q  <= ~i_Cmd_Write;
            wait_cnt_q <= '0;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          // Completion is checked first so a late waitrequest drop beats the timeout.
          if (!i_AV_WaitRequest) begin
            av_read_q   <= 1'b0;
            av_write_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= RSP_OK;
            rsp_rdata_q <= av_read_q ? i_AV_ReadData : '0;
            state_q     <= IDLE;
          end else if (timeout_hit) begin
            av_read_q   <= 1'b0;
            av_write_q  <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_code_q  <= RSP_TIMEOUT;
            rsp_rdata_q <= '0;
            state_q     <= IDLE;
          end else if (TIMEOUT_CYCLES != 0) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Cmd_Ready    = (state_q == IDLE);
  assign o_Rsp_Valid    = rsp_valid_q;
  assign o_Rsp_ReadData = rsp_rdata_q;
  assign o_Rsp_Error    = (rsp_code_q == RSP_TIMEOUT);
  assign o_AV_Addr      = av_addr_q;
  assign o_AV_ByteEn    = av_be_q;
  assign o_AV_Read      = av_read_q;
  assign o_AV_Write     = av_write_q;
  assign o_AV_WriteData = av_wdata_q;

endmodule : avalon_simple_master

`default_nettype wire

// File: tb/tb_avalon_simple_master.sv
// ----------------------------------------------------------------------------
// tb_avalon_simple_master : directed self-checking bench with a wait-state slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_avalon_simple_master;
  import av_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;

  logic                i_Clk = 1'b0;
  logic                i_Reset;
  logic                i_Cmd_Valid;
  logic                o_Cmd_Ready;
  logic                i_Cmd_Write;
  logic [AW-1:0]       i_Cmd_Addr;
  logic [BE_WIDTH-1:0] i_Cmd_ByteEn;
  logic [DW-1:0]       i_Cmd_WriteData;
  logic                o_Rsp_Valid;
  logic [DW-1:0]       o_Rsp_ReadData;
  logic                o_Rsp_Error;
  logic [AW-1:0]       o_AV_Addr;
  logic [BE_WIDTH-1:0] o_AV_ByteEn;
  logic                o_AV_Read;
  logic                o_AV_Write;
  logic [DW-1:0]       o_AV_WriteData;
  logic [DW-1:0]       i_AV_ReadData;
  logic                i_AV_WaitRequest;

  int n_cmp = 0;
  int n_bad = 0;

  avalon_simple_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset),
    .i_Cmd_Valid(i_Cmd_Valid), .o_Cmd_Ready(o_Cmd_Ready),
    .i_Cmd_Write(i_Cmd_Write), .i_Cmd_Addr(i_Cmd_Addr),
    .i_Cmd_ByteEn(i_Cmd_ByteEn), .i_Cmd_WriteData(i_Cmd_WriteData),
    .o_Rsp_Valid(o_Rsp_Valid), .o_Rsp_ReadData(o_Rsp_ReadData),
    .o_Rsp_Error(o_Rsp_Error), .o_AV_Addr(o_AV_Addr),
    .o_AV_ByteEn(o_AV_ByteEn), .o_AV_Read(o_AV_Read),
    .o_AV_Write(o_AV_Write), .o_AV_WriteData(o_AV_WriteData),
    .i_AV_ReadData(i_AV_ReadData), .i_AV_WaitRequest(i_AV_WaitRequest)
  );

  always #5 i_Clk = ~i_Clk;

  // Slave model: holds waitrequest for slv_waits strobe cycles, or forever when forced.
  int   slv_waits = 0;
  logic slv_force = 1'b0;
  int   slv_cnt   = 0;
  logic strobe;
  assign strobe = o_AV_Read | o_AV_Write;
  always @(posedge i_Clk) begin
    if (i_Reset || !strobe) slv_cnt <= 0;
    else                    slv_cnt <= slv_cnt + 1;
  end
  assign i_AV_WaitRequest = strobe && (slv_force || (slv_cnt < slv_waits));

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // Issues one command and watches the bus until the response; lat counts edges
  // from the acceptance edge to the completing edge, both inclusive.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr,
                         input logic [BE_WIDTH-1:0] be, input logic [DW-1:0] data,
                         output int strobes, output int lat, output logic first_strobe,
                         output logic stable, output logic [DW-1:0] rdata,
                         output logic err);
    logic got;
    i_Cmd_Valid = 1'b1; i_Cmd_Write = wr; i_Cmd_Addr = addr;
    i_Cmd_ByteEn = be; i_Cmd_WriteData = data;
    step();
    i_Cmd_Valid = 1'b0;
    i_Cmd_Addr = '1; i_Cmd_ByteEn = '1; i_Cmd_WriteData = '1;
    first_strobe = wr ? o_AV_Write : o_AV_Read;
    strobes = 0; lat = 1; stable = 1'b1; got = 1'b0; rdata = 'x; err = 1'bx;
    for (int k = 0; k < 40 && !got; k++) begin
      if (strobe) begin
        strobes++;
        if (o_AV_Addr !== addr || o_AV_ByteEn !== be || (o_AV_Read && o_AV_Write) ||
            o_AV_Write !== wr || (wr && o_AV_WriteData !== data))
          stable = 1'b0;
      end
      if (o_Rsp_Valid) begin
        got = 1'b1; rdata = o_Rsp_ReadData; err = o_Rsp_Error;
      end else begin
        step();
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Cmd_Valid = 1'b0; i_Cmd_Write = 1'b0;
    i_Cmd_Addr = '0; i_Cmd_ByteEn = '0; i_Cmd_WriteData = '0; i_AV_ReadData = '0;
    step(); step();
    i_Reset = 1'b0;
    n_cmp++;
    if ({o_AV_Read, o_AV_Write, o_Rsp_Valid, o_Rsp_Error} !== 4'b0 ||
        o_AV_Addr !== '0 || o_AV_ByteEn !== '0 || o_AV_WriteData !== '0 ||
        o_Rsp_ReadData !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rd=%b wr=%b rv=%b er=%b addr=%h be=%h wd=%h rd=%h, all required 0",
               o_AV_Read, o_AV_Write, o_Rsp_Valid, o_Rsp_Error, o_AV_Addr, o_AV_ByteEn,
               o_AV_WriteData, o_Rsp_ReadData);
    end
    n_cmp++;
    if (o_Cmd_Ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", o_Cmd_Ready);
    end
    step();
  endtask

  task automatic test_write_wait5();
    int s, l; logic f, st, e; logic [DW-1:0] r;
    slv_waits = 5;
    run_cmd(1'b1, 30'd0, 4'b1111, 32'h5A5A5A5A, s, l, f, st, r, e);
    n_cmp++;
    if (s !== 6 || l !== 7 || st !== 1'b1) begin
      n_bad++; $display("FAIL wr5_timing: strobes=%0d lat=%0d stable=%b want 6/7/1", s, l, st);
    end
    n_cmp++;
    if (e !== 1'b0 || r !== 32'h0) begin
      n_bad++; $display("FAIL wr5_rsp: err=%b rdata=%h want 0/0", e, r);
    end
    step();
    n_cmp++;
    if (o_Rsp_Valid !== 1'b0) begin
      n_bad++; $display("FAIL wr5_pulse: rsp_valid=%b after one cycle, want 0", o_Rsp_Valid);
    end
  endtask

  task automatic test_read_wait4();
    int s, l; logic f, st, e; logic [DW-1:0] r;
    slv_waits = 4; i_AV_ReadData = 32'h5A5A5A5A;
    run_cmd(1'b0, 30'd0, 4'b1111, 32'h0, s, l, f, st, r, e);
    n_cmp++;
    if (s !== 5 || l !== 6 || st !== 1'b1) begin
      n_bad++; $display("FAIL rd4_timing: strobes=%0d lat=%0d stable=%b want 5/6/1", s, l, st);
    end
    n_cmp++;
    if (r !== 32'h5A5A5A5A || e !== 1'b0) begin
      n_bad++; $display("FAIL rd4_rsp: rdata=%h err=%b want 5a5a5a5a/0", r, e);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int s, l; logic f, st, e; logic [DW-1:0] r;
    logic        wr_v [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0]  be_v [3] = '{4'b0011, 4'b0000, 4'b1000};
    logic [31:0] d_v  [3] = '{32'h11112222, 32'hDEADBEEF, 32'h0};
    logic [31:0] r_v  [3] = '{32'h0, 32'h0, 32'hCAFEF00D};
    slv_waits = 0; i_AV_ReadData = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      run_cmd(wr_v[i], AW'(i + 1), be_v[i], d_v[i], s, l, f, st, r, e);
      n_cmp++;
      if (s !== 1 || l !== 2 || f !== 1'b1 || st !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_timing[%0d]: strobes=%0d lat=%0d first=%b stable=%b want 1/2/1/1",
                 i, s, l, f, st);
      end
      n_cmp++;
      if (r !== r_v[i] || e !== 1'b0 || strobe !== 1'b0 || o_Cmd_Ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_rsp[%0d]: rdata=%h err=%b strobe=%b ready=%b want %h/0/0/1",
                 i, r, e, strobe, o_Cmd_Ready, r_v[i]);
      end
    end
    step();
  endtask

  task automatic test_timeout();
    int s, l; logic f, st, e; logic [DW-1:0] r;
    i_AV_ReadData = 32'h13579BDF;
    slv_force = 1'b1;
    run_cmd(1'b0, 30'h55, 4'b1111, 32'h0, s, l, f, st, r, e);
    slv_force = 1'b0;
    n_cmp++;
    if (s !== TO || l !== TO + 1 || st !== 1'b1) begin
      n_bad++; $display("FAIL to_abort_timing: strobes=%0d lat=%0d stable=%b want 8/9/1", s, l, st);
    end
    n_cmp++;
    if (e !== 1'b1 || r !== 32'h0) begin
      n_bad++; $display("FAIL to_abort_rsp: err=%b rdata=%h want 1/0", e, r);
    end
    step();
    slv_waits = TO - 1;
    run_cmd(1'b0, 30'h56, 4'b1111, 32'h0, s, l, f, st, r, e);
    n_cmp++;
    if (s !== TO || l !== TO + 1 || e !== 1'b0 || r !== 32'h13579BDF) begin
      n_bad++;
      $display("FAIL to_edge_complete: strobes=%0d lat=%0d err=%b rdata=%h want 8/9/0/13579bdf",
               s, l, e, r);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int bad_rsp = 0;
    slv_waits = 6;
    i_Cmd_Valid = 1'b1; i_Cmd_Write = 1'b1; i_Cmd_Addr = 30'h3A5;
    i_Cmd_ByteEn = 4'b0110; i_Cmd_WriteData = 32'hA5A5F00F;
    step();
    i_Cmd_Valid = 1'b0;
    step(); step();
    i_Reset = 1'b1;
    step();
    n_cmp++;
    if (o_AV_Read !== 1'b0 || o_AV_Write !== 1'b0 || o_AV_Addr !== '0 ||
        o_AV_ByteEn !== '0 || o_AV_WriteData !== '0 || o_Rsp_Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_bus: rd=%b wr=%b addr=%h be=%h wd=%h rv=%b want all 0",
               o_AV_Read, o_AV_Write, o_AV_Addr, o_AV_ByteEn, o_AV_WriteData, o_Rsp_Valid);
    end
    i_Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (o_Rsp_Valid !== 1'b0 || strobe !== 1'b0) bad_rsp++;
    end
    n_cmp++;
    if (o_Cmd_Ready !== 1'b1 || bad_rsp != 0) begin
      n_bad++;
      $display("FAIL rst_mid_after: ready=%b stray_cycles=%0d want 1/0", o_Cmd_Ready, bad_rsp);
    end
  endtask

  task automatic test_not_ready_hold();
    int bad_addr = 0;
    logic done = 1'b0;
    slv_waits = 3;
    i_Cmd_Valid = 1'b1; i_Cmd_Write = 1'b1; i_Cmd_Addr = 30'h10;
    i_Cmd_ByteEn = 4'b1111; i_Cmd_WriteData = 32'h01020304;
    step();
    i_Cmd_Addr = 30'h20;
    for (int k = 0; k < 20 && !done; k++) begin
      if (o_Rsp_Valid) done = 1'b1;
      else begin
        if (o_AV_Addr !== 30'h10 || o_Cmd_Ready !== 1'b0) bad_addr++;
        step();
      end
    end
    n_cmp++;
    if (bad_addr != 0 || !done) begin
      n_bad++; $display("FAIL hold_addr: bad_cycles=%0d done=%b want 0/1", bad_addr, done);
    end
    step();
    i_Cmd_Valid = 1'b0;
    n_cmp++;
    if (o_AV_Write !== 1'b1 || o_AV_Addr !== 30'h20) begin
      n_bad++; $display("FAIL hold_accept: wr=%b addr=%h want 1/20", o_AV_Write, o_AV_Addr);
    end
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (o_Rsp_Valid) done = 1'b1;
      else step();
    end
    n_cmp++;
    if (!done || o_Rsp_Error !== 1'b0) begin
      n_bad++; $display("FAIL hold_second_rsp: done=%b err=%b want 1/0", done, o_Rsp_Error);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write_wait5();
    test_read_wait4();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_not_ready_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

endmodule : tb_avalon_simple_master

`default_nettype wire
